seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
Time-multiplexing controller for the board's common-anode 7-segment display. Holds one glyph per digit and scans the digits round-robin, driving one anode at a time, so the recorder logic can show channel number, mode and counters on all digits at once. Producers write digits through a valid/ready update port into a shadow bank. The shadow bank is copied to the displayed bank only at frame boundaries, so a frame never shows a partial update.

Parameters:
NUM_DIGITS, 8, number of digits scanned (1..8).
REFRESH_DIV, 100000, clk cycles per digit slot (1 ms at 100 MHz); must be > BLANK_CYCLES.
BLANK_CYCLES, 16, anti-ghosting cycles at the start of each slot with all anodes off (>= 1).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  1 = scan; 0 = display dark
upd_valid  in  1  producer has a digit update
upd_ready  out  1  controller accepts an update this cycle
upd_digit  in  3  target digit index; 0 = anod[0]
upd_value  in  4  hex glyph 0-F
upd_blank  in  1  1 = digit dark, upd_value ignored
upd_dp  in  1  1 = decimal point on
led_pins  out  7  segments, active-low; [0] = Sa ... [6] = Sg
dp_n  out  1  decimal point, active-low
anod  out  NUM_DIGITS  digit anodes, active-low
frame_tick  out  1  one-cycle pulse at the end of each full scan

Behaviour:
- Reset (async on rst_n low):
  - anod all 1, led_pins = 7'b1111111, dp_n = 1, frame_tick = 0, upd_ready = 0.
  - Both banks cleared to blank, scan state = OFF, digit index = 0, slot counter = 0.
  - upd_ready rises on the first clk edge after rst_n deasserts.
- Glyph encoding (active-low, g..a):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
  - 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011, C = 1000110, d = 0100001, E = 0000110, F = 0001110
  - blank = 1111111.
- Update handshake:
  - Transfer occurs on a clk edge with upd_valid & upd_ready; it writes {blank, value, dp} into shadow[upd_digit].
  - upd_digit >= NUM_DIGITS: accepted and discarded.
  - upd_ready = 0 only during reset and during the single commit cycle.
- States:
  - OFF: enable = 0. Outputs dark. The active bank copies the shadow bank every cycle, with no commit stall. On enable = 1 -> BLANK, digit 0, slot counter 0.
  - BLANK: anod all 1, led_pins/dp_n all 1. After BLANK_CYCLES cycles -> DRIVE.
  - DRIVE: anod[digit] = 0, all others 1; led_pins and dp_n show active[digit]. At slot counter = REFRESH_DIV-1, go to BLANK with digit+1. After the last digit, wrap to digit 0.
- Slot timing:
  - Outputs are registered. Each slot is exactly REFRESH_DIV cycles on the outputs: BLANK_CYCLES blank, then REFRESH_DIV-BLANK_CYCLES lit.
  - One frame = NUM_DIGITS*REFRESH_DIV cycles.
- Commit:
  - Occurs in the last cycle of the last digit's slot.
  - In that cycle: active <= shadow, frame_tick = 1, upd_ready = 0.
  - The first digit of the next frame shows the committed data.
  - A producer holding upd_valid through the commit cycle is accepted the next cycle, with no loss.
- enable falling mid-slot: the next edge forces the OFF outputs. The scan restarts at digit 0 with BLANK on re-enable. No frame_tick is issued for the truncated frame.
- Reset mid-scan: immediate dark outputs (async), all state cleared as at reset.

Test Plan:
(Sim params: NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.)
1. Reset, enable=1, no updates -> anod cycles 1111 for 2 cycles then 1110 for 6, then 1111/1101, and so on; led_pins = 1111111 throughout; frame_tick pulses every 32 cycles.
2. Write digit0=1, digit3=8 with dp mid-frame -> both unchanged until frame_tick; next frame: anod=1110 gives led_pins=1111001, dp_n=1; anod=0111 gives led_pins=0000000, dp_n=0.
3. Hold upd_valid continuously across a commit -> upd_ready=0 exactly in the frame_tick cycle; the update is accepted on the following edge; one transfer per accepted cycle.
4. Update with upd_digit=5 -> accepted (upd_ready=1); no displayed digit changes.
5. Drop enable during digit2 DRIVE -> next edge anod=1111, led_pins=1111111; a write while disabled is visible immediately on re-enable at digit 0 after 2 blank cycles.
6. Assert rst_n=0 mid-DRIVE between clk edges -> anod=1111, upd_ready=0 immediately; after release, all digits blank.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed common-anode 7-segment scanner with a shadow/active glyph bank.
// Producers write the shadow bank; it is copied to the displayed bank only at frame boundaries.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  upd_valid,
  output logic                  upd_ready,
  input  logic [2:0]            upd_digit,
  input  logic [3:0]            upd_value,
  input  logic                  upd_blank,
  input  logic                  upd_dp,
  output logic [6:0]            led_pins,
  output logic                  dp_n,
  output logic [NUM_DIGITS-1:0] anod,
  output logic                  frame_tick
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] SLOT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [2:0]    DIGIT_LAST = 3'(NUM_DIGITS - 1);
  localparam logic [3:0]    DIGIT_CNT  = 4'(NUM_DIGITS);
  localparam logic [5:0]    ENT_BLANK  = 6'b10_0000;

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_BLANK = 2'd1,
    S_DRIVE = 2'd2
  } state_t;

  state_t                  state, state_nx;
  logic [CW-1:0]           cnt, cnt_nx;
  logic [2:0]              digit, digit_nx;
  // Bank entry layout: {blank, value[3:0], dp}; sized for the full 3-bit digit index.
  logic [5:0]              shadow [8];
  logic [5:0]              active [8];
  logic                    commit;
  logic                    accept;
  logic                    drive_nx;
  logic [NUM_DIGITS-1:0]   anod_nx;
  logic [6:0]              led_nx;
  logic                    dp_nx;
  logic                    tick_nx;

  function automatic logic [6:0] glyph(input logic [5:0] ent);
    logic [6:0] seg;
    if (ent[5]) begin
      seg = 7'b111_1111;
    end else begin
      case (ent[4:1])
        4'h0:    seg = 7'b100_0000;
        4'h1:    seg = 7'b111_1001;
        4'h2:    seg = 7'b010_0100;
        4'h3:    seg = 7'b011_0000;
        4'h4:    seg = 7'b001_1001;
        4'h5:    seg = 7'b001_0010;
        4'h6:    seg = 7'b000_0010;
        4'h7:    seg = 7'b111_1000;
        4'h8:    seg = 7'b000_0000;
        4'h9:    seg = 7'b001_0000;
        4'hA:    seg = 7'b000_1000;
        4'hB:    seg = 7'b000_0011;
        4'hC:    seg = 7'b100_0110;
        4'hD:    seg = 7'b010_0001;
        4'hE:    seg = 7'b000_0110;
        4'hF:    seg = 7'b000_1110;
        default: seg = 7'b111_1111;
      endcase
    end
    return seg;
  endfunction

  assign accept = upd_valid & upd_ready;
  assign commit = (state == S_DRIVE) && (cnt == SLOT_LAST) && (digit == DIGIT_LAST);

  // Scan sequencer: slot counter runs 0..REFRESH_DIV-1 across BLANK then DRIVE.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    digit_nx = digit;
    if (!enable) begin
      state_nx = S_OFF;
      cnt_nx   = '0;
      digit_nx = 3'd0;
    end else begin
      case (state)
        S_OFF: begin
          state_nx = S_BLANK;
          cnt_nx   = '0;
          digit_nx = 3'd0;
        end
        S_BLANK: begin
          if (cnt == BLANK_LAST) begin
            state_nx = S_DRIVE;
          end else begin
            state_nx = S_BLANK;
          end
          cnt_nx = cnt + CW'(1);
        end
        S_DRIVE: begin
          if (cnt == SLOT_LAST) begin
            state_nx = S_BLANK;
            cnt_nx   = '0;
            if (digit == DIGIT_LAST) begin
              digit_nx = 3'd0;
            end else begin
              digit_nx = digit + 3'd1;
            end
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
        default: begin
          state_nx = S_OFF;
          cnt_nx   = '0;
          digit_nx = 3'd0;
        end
      endcase
    end
  end

  // Output values for the upcoming cycle, so the registered pins track the scan state exactly.
  always_comb begin
    drive_nx = (state_nx == S_DRIVE);
    anod_nx  = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (drive_nx && (digit_nx == 3'(i))) begin
        anod_nx[i] = 1'b0;
      end else begin
        anod_nx[i] = 1'b1;
      end
    end
    if (drive_nx) begin
      led_nx = glyph(active[digit_nx]);
      dp_nx  = ~active[digit_nx][0];
    end else begin
      led_nx = 7'b111_1111;
      dp_nx  = 1'b1;
    end
    tick_nx = drive_nx && (cnt_nx == SLOT_LAST) && (digit_nx == DIGIT_LAST);
  end

  // Scan state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_OFF;
      cnt   <= '0;
      digit <= 3'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      digit <= digit_nx;
    end
  end

  // Glyph banks: shadow takes producer writes, active follows shadow while dark or at commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        shadow[i] <= ENT_BLANK;
        active[i] <= ENT_BLANK;
      end
    end else begin
      if (accept && ({1'b0, upd_digit} < DIGIT_CNT)) begin
        shadow[upd_digit] <= {upd_blank, upd_value, upd_dp};
      end
      if ((state == S_OFF) || commit) begin
        active <= shadow;
      end
    end
  end

  // Registered pins; upd_ready drops only for the commit cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anod       <= '1;
      led_pins   <= 7'b111_1111;
      dp_n       <= 1'b1;
      frame_tick <= 1'b0;
      upd_ready  <= 1'b0;
    end else begin
      anod       <= anod_nx;
      led_pins   <= led_nx;
      dp_n       <= dp_nx;
      frame_tick <= tick_nx;
      upd_ready  <= ~tick_nx;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
// Cycle numbers count clk edges after rst_n release; frame k ends with frame_tick after edge 32*k.
module tb_seg_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       upd_valid;
  logic       upd_ready;
  logic [2:0] upd_digit;
  logic [3:0] upd_value;
  logic       upd_blank;
  logic       upd_dp;
  logic [6:0] led_pins;
  logic       dp_n;
  logic [3:0] anod;
  logic       frame_tick;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int next_tick = 32;
  bit track   = 1'b0;

  seg_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .upd_valid  (upd_valid),
    .upd_ready  (upd_ready),
    .upd_digit  (upd_digit),
    .upd_value  (upd_value),
    .upd_blank  (upd_blank),
    .upd_dp     (upd_dp),
    .led_pins   (led_pins),
    .dp_n       (dp_n),
    .anod       (anod),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%0h, want 0x%0h", tag, cyc, got, exp);
    end
  endtask

  // One clk edge; while tracking, frame_tick and upd_ready are checked every cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    if (track) begin
      cyc++;
      check("frame_tick", {31'd0, frame_tick}, {31'd0, cyc == next_tick});
      check("upd_ready", {31'd0, upd_ready}, {31'd0, cyc != next_tick});
      if (cyc == next_tick) next_tick += 32;
    end
  endtask

  task automatic tick_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic look(input string tag, input logic [3:0] ea, input logic [6:0] el, input logic ed);
    check({tag, ".anod"}, {28'd0, anod}, {28'd0, ea});
    check({tag, ".led"}, {25'd0, led_pins}, {25'd0, el});
    check({tag, ".dp_n"}, {31'd0, dp_n}, {31'd0, ed});
  endtask

  task automatic write(input logic [2:0] d, input logic [3:0] v, input logic b, input logic p);
    upd_valid = 1'b1;
    upd_digit = d;
    upd_value = v;
    upd_blank = b;
    upd_dp    = p;
    check("wr_ready", {31'd0, upd_ready}, 32'd1);
    tick();
    upd_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; upd_valid = 1'b0;
    upd_digit = 3'd0; upd_value = 4'd0; upd_blank = 1'b0; upd_dp = 1'b0;

    // Reset state
    #22;
    look("rst", 4'b1111, 7'b111_1111, 1'b1);
    check("rst.frame_tick", {31'd0, frame_tick}, 32'd0);
    check("rst.upd_ready", {31'd0, upd_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel.upd_ready", {31'd0, upd_ready}, 32'd0);
    track = 1'b1;

    // Test 1: empty scan of the first frame
    for (int i = 1; i <= 32; i++) begin
      logic [3:0] ea;
      int slot;
      int c;
      tick();
      slot = (i - 1) / 8;
      c    = (i - 1) % 8;
      ea   = 4'b1111;
      if (c >= 2) ea[slot] = 1'b0;
      look("scan", ea, 7'b111_1111, 1'b1);
    end

    // Test 2: writes mid-frame stay hidden until the commit
    tick();
    write(3'd0, 4'h1, 1'b0, 1'b0);
    write(3'd3, 4'h8, 1'b0, 1'b1);
    look("hold_d0", 4'b1110, 7'b111_1111, 1'b1);
    tick_to(59); look("hold_d3", 4'b0111, 7'b111_1111, 1'b1);
    tick_to(67); look("show_d0", 4'b1110, 7'b111_1001, 1'b1);
    tick_to(75); look("show_d1", 4'b1101, 7'b111_1111, 1'b1);
    tick_to(91); look("show_d3", 4'b0111, 7'b000_0000, 1'b0);

    // Test 3: upd_valid held across the commit at edge 96
    tick_to(93);
    upd_valid = 1'b1; upd_digit = 3'd1; upd_blank = 1'b0; upd_dp = 1'b0;
    upd_value = 4'h2; tick();
    upd_value = 4'h3; tick();
    upd_value = 4'h4; tick();
    upd_value = 4'h5; tick();
    check("stall_ready", {31'd0, upd_ready}, 32'd1);
    tick();
    upd_valid = 1'b0;
    tick_to(107); look("commit_d1", 4'b1101, 7'b001_1001, 1'b1);
    tick_to(139); look("late_d1", 4'b1101, 7'b001_0010, 1'b1);

    // Test 4: out-of-range digit is accepted and dropped
    write(3'd5, 4'h0, 1'b0, 1'b0);
    tick_to(163); look("oor_d0", 4'b1110, 7'b111_1001, 1'b1);
    tick_to(171); look("oor_d1", 4'b1101, 7'b001_0010, 1'b1);
    tick_to(179); look("oor_d2", 4'b1011, 7'b111_1111, 1'b1);
    tick_to(187); look("oor_d3", 4'b0111, 7'b000_0000, 1'b0);

    // Test 5: enable dropped during digit 2 DRIVE, write while dark
    tick_to(211); look("pre_off", 4'b1011, 7'b111_1111, 1'b1);
    tick_to(212);
    enable = 1'b0;
    next_tick = 32'h4000_0000;
    tick(); look("off", 4'b1111, 7'b111_1111, 1'b1);
    write(3'd0, 4'hA, 1'b0, 1'b0);
    tick_to(216);
    look("off_hold", 4'b1111, 7'b111_1111, 1'b1);
    enable = 1'b1;
    next_tick = 248;
    tick(); look("re_blank0", 4'b1111, 7'b111_1111, 1'b1);
    tick(); look("re_blank1", 4'b1111, 7'b111_1111, 1'b1);
    tick(); look("re_d0", 4'b1110, 7'b000_1000, 1'b1);

    // Test 6: asynchronous reset between edges
    #3;
    rst_n = 1'b0;
    track = 1'b0;
    #1;
    look("arst", 4'b1111, 7'b111_1111, 1'b1);
    check("arst.upd_ready", {31'd0, upd_ready}, 32'd0);
    check("arst.frame_tick", {31'd0, frame_tick}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    next_tick = 32;
    track = 1'b1;
    tick_to(3);  look("clr_d0", 4'b1110, 7'b111_1111, 1'b1);
    tick_to(11); look("clr_d1", 4'b1101, 7'b111_1111, 1'b1);
    tick_to(27); look("clr_d3", 4'b0111, 7'b111_1111, 1'b1);
    tick_to(35); look("clr_next_d0", 4'b1110, 7'b111_1111, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
